comp_n_seq: RTL and testbench

Sequential, parametrised successor to the three-point combinational min/max comparator in the triangle setup path. Accepts one primitive per handshake: NUM_VERT vertices, each with CHANNELS IEEE-754 single-precision coordinates (x, y, ...). Folds one vertex per cycle across all channels in parallel. Returns per-channel minimum, maximum, the index of each, and a NaN flag to the bounding-box/edge-setup stage.

---
 rtl/comp_pkg.sv | 31 +++
 rtl/fp_order_cmp.sv | 24 ++
 rtl/comp_n_seq.sv | 172 +++++++++++++++++
 tb/tb_comp_n_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// comp_pkg: shared float field widths, FSM encoding and ordering helpers for
// the sequential min/max comparator.
package comp_pkg;

  localparam int FW     = 32;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Vertex index width; a single-vertex primitive still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Map a float onto an unsigned key whose natural order is the total order
  // -NaN < -inf < ... < -0 < +0 < ... < +inf < +NaN.
  function automatic logic [FW-1:0] fp_key(input logic [FW-1:0] f);
    return f[FW-1] ? ~f : (f ^ {1'b1, {(FW-SIGN_W){1'b0}}});
  endfunction

  function automatic logic fp_isnan(input logic [FW-1:0] f);
    return (f[FW-2 -: EXP_W] == {EXP_W{1'b1}}) && (f[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// fp_order_cmp: combinational total-order compare of two single-precision
// floats, plus NaN detection on both operands.
module fp_order_cmp
  import comp_pkg::*;
(
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic          a_lt_b,
  output logic          a_gt_b,
  output logic          a_nan,
  output logic          b_nan
);

  logic [FW-1:0] a_key;
  logic [FW-1:0] b_key;

  assign a_key  = fp_key(a);
  assign b_key  = fp_key(b);
  assign a_lt_b = a_key < b_key;
  assign a_gt_b = a_key > b_key;
  assign a_nan  = fp_isnan(a);
  assign b_nan  = fp_isnan(b);

endmodule

// File: rtl/comp_n_seq.sv
// comp_n_seq: accepts one primitive per handshake and folds one vertex per
// cycle into per-channel running min/max, their vertex indices and a NaN flag.
module comp_n_seq #(
  parameter int NUM_VERT = 3,
  parameter int CHANNELS = 2,
  parameter int FW       = 32,  // single precision only
  parameter int IW       = comp_pkg::idx_width(NUM_VERT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_VERT*CHANNELS*FW-1:0] in_coords,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*FW-1:0]       min_out,
  output logic [CHANNELS*FW-1:0]       max_out,
  output logic [CHANNELS*IW-1:0]       min_idx,
  output logic [CHANNELS*IW-1:0]       max_idx,
  output logic [CHANNELS-1:0]          nan_flag
);

  import comp_pkg::*;

  state_t state_q, state_d;
  logic   load, fold;

  logic [NUM_VERT*CHANNELS*FW-1:0] cap_q;
  logic [IW-1:0]                   vcnt_q;

  logic [CHANNELS-1:0][FW-1:0] in_v0, cur;
  logic [CHANNELS-1:0][FW-1:0] min_q, max_q;
  logic [CHANNELS-1:0][IW-1:0] min_idx_q, max_idx_q;
  logic [CHANNELS-1:0]         nan_q;

  logic [CHANNELS-1:0] mn_lt, mn_gt, mn_an, mn_bn;
  logic [CHANNELS-1:0] mx_lt, mx_gt, mx_an, mx_bn;

  // Vertex 0 seeds the running results straight from the input bus.
  assign in_v0 = in_coords[CHANNELS*FW-1:0];

  // Next state and handshake; a new primitive may be taken in DONE as soon
  // as the consumer releases the current result.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value unassigned (no latches).
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    fold      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = (NUM_VERT == 1) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        fold = 1'b1;
        if (vcnt_q == IW'(NUM_VERT - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load    = 1'b1;
            state_d = (NUM_VERT == 1) ? ST_DONE : ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the vertex being folded this cycle out of the capture register.
  always_comb begin
    cur = '0;
    for (int v = 0; v < NUM_VERT; v++) begin
      if (vcnt_q == IW'(v)) cur = cap_q[v*CHANNELS*FW +: CHANNELS*FW];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fp_order_cmp u_min (
      .a      (cur[c]),
      .b      (min_q[c]),
      .a_lt_b (mn_lt[c]),
      .a_gt_b (mn_gt[c]),
      .a_nan  (mn_an[c]),
      .b_nan  (mn_bn[c])
    );
    fp_order_cmp u_max (
      .a      (cur[c]),
      .b      (max_q[c]),
      .a_lt_b (mx_lt[c]),
      .a_gt_b (mx_gt[c]),
      .a_nan  (mx_an[c]),
      .b_nan  (mx_bn[c])
    );
  end

  // Capture the whole primitive on acceptance; inputs are not looked at again.
  // NOTE: pure datapath storage, only read while SCAN is active, so it has no
  // reset; that keeps the wide register free of reset fan-out.
  always_ff @(posedge clk) begin
    if (load) cap_q <= in_coords;
  end

  // State, vertex counter and running results; reset clears them so a
  // primitive interrupted by reset leaves no partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vcnt_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      nan_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        vcnt_q <= IW'(1);
        for (int c = 0; c < CHANNELS; c++) begin
          min_q[c]     <= in_v0[c];
          max_q[c]     <= in_v0[c];
          min_idx_q[c] <= '0;
          max_idx_q[c] <= '0;
          nan_q[c]     <= fp_isnan(in_v0[c]);
        end
      end else if (fold) begin
        vcnt_q <= vcnt_q + IW'(1);
        for (int c = 0; c < CHANNELS; c++) begin
          // Strict compares keep the lowest index on equal keys.
          if (mn_lt[c]) begin
            min_q[c]     <= cur[c];
            min_idx_q[c] <= vcnt_q;
          end
          if (mx_gt[c]) begin
            max_q[c]     <= cur[c];
            max_idx_q[c] <= vcnt_q;
          end
          nan_q[c] <= nan_q[c] | mn_an[c];
        end
      end
    end
  end

  // Fold invariants: running min never exceeds running max, both banks agree
  // on the incoming vertex, and a NaN already held is already flagged.
  always_comb begin
    if (rst_n && state_q == ST_SCAN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        assert (!(mn_lt[c] && !mx_lt[c]) && !(mx_gt[c] && !mn_gt[c]));
        assert (mn_an[c] == mx_an[c]);
        assert (!(mn_bn[c] || mx_bn[c]) || nan_q[c]);
      end
    end
  end

  assign min_out  = min_q;
  assign max_out  = max_q;
  assign min_idx  = min_idx_q;
  assign max_idx  = max_idx_q;
  assign nan_flag = nan_q;

endmodule

// File: tb/tb_comp_n_seq.sv
// tb_comp_n_seq: three configurations (3x2, 1x2, 4x3) checked every cycle
// against an ordinal-arithmetic model, with directed literal cases on 3x2.
module tb_comp_n_seq;

  logic clk = 1'b0;
  logic rst_n;
  bit   go = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mn[3];
    logic [31:0] mx[3];
    int          mni[3];
    int          mxi[3];
    bit          nan[3];
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Signed ordinal of a float: positives keep their magnitude, negatives map
  // below zero with larger magnitude further down (-0 -> -1).
  function automatic longint ord(input logic [31:0] f);
    return f[31] ? (-longint'(f[30:0]) - 1) : longint'(f[30:0]);
  endfunction

  function automatic res_t model(input logic [383:0] co, input int n, input int c);
    res_t r;
    for (int ch = 0; ch < 3; ch++) begin
      r.mn[ch] = '0; r.mx[ch] = '0; r.mni[ch] = 0; r.mxi[ch] = 0; r.nan[ch] = 1'b0;
    end
    for (int ch = 0; ch < c; ch++) begin
      for (int v = 0; v < n; v++) begin
        logic [31:0] f;
        f = co[(v*c+ch)*32 +: 32];
        if (f[30:23] == 8'hFF && f[22:0] != 0) r.nan[ch] = 1'b1;
        if (ord(f) < ord(co[(r.mni[ch]*c+ch)*32 +: 32])) r.mni[ch] = v;
        if (ord(f) > ord(co[(r.mxi[ch]*c+ch)*32 +: 32])) r.mxi[ch] = v;
      end
      r.mn[ch] = co[(r.mni[ch]*c+ch)*32 +: 32];
      r.mx[ch] = co[(r.mxi[ch]*c+ch)*32 +: 32];
    end
    return r;
  endfunction

  // Random float biased towards specials and a small pool so ties occur.
  function automatic logic [31:0] rand_f();
    case ($urandom_range(0, 11))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h3F80_0000;
      5: return 32'hBF80_0000;
      6: return 32'h7FC0_0000;
      7: return 32'hFFC0_0001;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int NV  = (g == 1) ? 1 : (g == 2) ? 4 : 3;
    localparam int CH  = (g == 2) ? 3 : 2;
    localparam int IWG = (NV > 1) ? $clog2(NV) : 1;

    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [NV*CH*32-1:0]  in_coords;
    logic [CH*32-1:0]     min_out, max_out;
    logic [CH*IWG-1:0]    min_idx, max_idx;
    logic [CH-1:0]        nan_flag;
    bit                   done = 1'b0;

    bit   have = 1'b0;
    int   age = 0;
    bit   exp_ov, exp_ir;
    res_t exp_r;

    comp_n_seq #(.NUM_VERT(NV), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coords (in_coords),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .min_out   (min_out),
      .max_out   (max_out),
      .min_idx   (min_idx),
      .max_idx   (max_idx),
      .nan_flag  (nan_flag)
    );

    // Per-cycle compare: handshake timing from accept age, data from model.
    always @(negedge clk) begin
      if (!rst_n) begin
        have = 1'b0;
        check($sformatf("c%0d rst out_valid", g), 64'(out_valid), 64'd0);
        check($sformatf("c%0d rst in_ready", g), 64'(in_ready), 64'd1);
        check($sformatf("c%0d rst outputs zero", g),
              64'({min_out, max_out, min_idx, max_idx, nan_flag} == '0), 64'd1);
      end else begin
        if (have) age++;
        exp_ov = have && (age >= NV - 1);
        exp_ir = !have || (exp_ov && out_ready);
        check($sformatf("c%0d out_valid", g), 64'(out_valid), 64'(exp_ov));
        check($sformatf("c%0d in_ready", g), 64'(in_ready), 64'(exp_ir));
        if (exp_ov) begin
          for (int ch = 0; ch < CH; ch++) begin
            check($sformatf("c%0d min ch%0d", g, ch), 64'(min_out[ch*32 +: 32]), 64'(exp_r.mn[ch]));
            check($sformatf("c%0d max ch%0d", g, ch), 64'(max_out[ch*32 +: 32]), 64'(exp_r.mx[ch]));
            check($sformatf("c%0d min_idx ch%0d", g, ch), 64'(min_idx[ch*IWG +: IWG]), 64'(exp_r.mni[ch]));
            check($sformatf("c%0d max_idx ch%0d", g, ch), 64'(max_idx[ch*IWG +: IWG]), 64'(exp_r.mxi[ch]));
            check($sformatf("c%0d nan ch%0d", g, ch), 64'(nan_flag[ch]), 64'(exp_r.nan[ch]));
          end
          if (out_ready) have = 1'b0;
        end
        if (in_valid && exp_ir) begin
          exp_r = model(384'(in_coords), NV, CH);
          have  = 1'b1;
          age   = -1;
        end
      end
    end

    task automatic run_random(input int cycles);
      for (int i = 0; i < cycles; i++) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < NV*CH; k++) in_coords[k*32 +: 32] = rand_f();
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (NV + 4) @(posedge clk);
    endtask

    if (g == 0) begin : dir
      localparam logic [191:0] T1 = {32'h4110_0000, 32'h4120_0000, 32'hC110_0000,
                                     32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000};
      localparam logic [191:0] T2 = {32'h0000_0000, 32'h3F80_0000, 32'h8000_0000,
                                     32'h4000_0000, 32'h0000_0000, 32'h4000_0000};
      localparam logic [191:0] T3 = {32'hBF80_0000, 32'h4000_0000, 32'h3F80_0000,
                                     32'h7FC0_0000, 32'h0000_0000, 32'h3F80_0000};

      // Offer a primitive (called just after a rising edge) and return just
      // after the edge that accepted it.
      task automatic send(input logic [191:0] co);
        int k;
        in_valid  = 1'b1;
        in_coords = co;
        for (k = 0; k < 20; k++) begin
          @(negedge clk);
          if (in_ready) break;
        end
        check("c0 accept within budget", 64'(k < 20), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
      endtask

      task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) break;
          lat++;
        end
      endtask

      initial begin
        int          lat;
        logic [63:0] snap_mn, snap_mx;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_coords = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n  = 1'b1;

        // Plain primitive.
        @(posedge clk); #1;
        send(T1);
        wait_valid(lat);
        check("t1 latency", 64'(lat), 64'd2);
        check("t1 min_out", 64'(min_out), 64'hC110_0000_3F80_0000);
        check("t1 max_out", 64'(max_out), 64'h4110_0000_4120_0000);
        check("t1 min_idx", 64'(min_idx), 64'h4);
        check("t1 max_idx", 64'(max_idx), 64'hA);
        check("t1 nan_flag", 64'(nan_flag), 64'd0);

        // Ties and signed zero.
        @(posedge clk); #1;
        send(T2);
        wait_valid(lat);
        check("t2 min_out", 64'(min_out), 64'h8000_0000_3F80_0000);
        check("t2 max_out", 64'(max_out), 64'h0000_0000_4000_0000);
        check("t2 min_idx", 64'(min_idx), 64'h6);
        check("t2 max_idx", 64'(max_idx), 64'h0);

        // NaN in x.
        @(posedge clk); #1;
        send(T3);
        wait_valid(lat);
        check("t3 nan_flag", 64'(nan_flag), 64'h1);
        check("t3 max x", 64'(max_out[31:0]), 64'h7FC0_0000);
        check("t3 max_idx x", 64'(max_idx[1:0]), 64'd1);

        // Backpressure with a second primitive waiting.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(T1);
        in_valid  = 1'b1;
        in_coords = T2;
        wait_valid(lat);
        check("t4 first latency", 64'(lat), 64'd2);
        snap_mn = 64'(min_out);
        snap_mx = 64'(max_out);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("t4 in_ready held low", 64'(in_ready), 64'd0);
          check("t4 min stable", 64'(min_out), snap_mn);
          check("t4 max stable", 64'(max_out), snap_mx);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 handoff in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check("t4 second latency", 64'(lat), 64'd2);
        check("t4 second min_out", 64'(min_out), 64'h8000_0000_3F80_0000);

        // Asynchronous reset one cycle into a scan.
        @(posedge clk); #1;
        send(T1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t5 out_valid", 64'(out_valid), 64'd0);
        check("t5 in_ready", 64'(in_ready), 64'd1);
        check("t5 min_out", 64'(min_out), 64'd0);
        check("t5 max_idx", 64'(max_idx), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(T3);
        wait_valid(lat);
        check("t5 after latency", 64'(lat), 64'd2);
        check("t5 after nan_flag", 64'(nan_flag), 64'h1);
        check("t5 after max x", 64'(max_out[31:0]), 64'h7FC0_0000);

        go = 1'b1;
        run_random(400);
        done = 1'b1;
      end
    end else begin : rnd
      initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_coords = '0;
        wait (go);
        run_random(400);
        done = 1'b1;
      end
    end
  end

  initial begin
    wait (cfg[0].done && cfg[1].done && cfg[2].done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
